aurora_tx_arbiter: RTL and testbench

//  Packet-level round-robin arbiter: shares the 32-bit AXI-stream TX input of the Aurora link between
//  NUM_PORTS requesters. Sits in the auUserClk domain, directly in front of the link's axiTxT* port.
//  A grant is held for a whole packet (until the tlast beat is accepted); packets are never interleaved.

---
 rtl/aurora_tx_arbiter_pkg.sv | 18 +
 rtl/aurora_tx_arbiter_rr_picker.sv | 45 ++++
 rtl/aurora_tx_arbiter.sv | 132 +++++++++++++
 tb/tb_aurora_tx_arbiter.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aurora_tx_arbiter_pkg.sv
// Shared types and constants for the Aurora TX packet arbiter.
// Used by aurora_tx_arbiter and rrPicker.
package auroraTxArbPkg;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_PASS = 1'b1
  } arbState_t;

  localparam int MAX_PORTS = 8;
  localparam int BEAT_W    = 32;

  // Index width for a port count; a single port still needs one select bit.
  function automatic int idxWidth(input int nPorts);
    return (nPorts > 1) ? $clog2(nPorts) : 1;
  endfunction

endpackage

// File: rtl/aurora_tx_arbiter_rr_picker.sv
// Combinational round-robin picker: first requester at or after ptr,
// wrapping modulo NUM_PORTS, returned as one-hot and as an index.
module rrPicker
  import auroraTxArbPkg::*;
#(
  parameter int NUM_PORTS = 4,
  parameter int IDX_W     = idxWidth(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [IDX_W-1:0]     ptr,
  output logic [NUM_PORTS-1:0] pickOh,
  output logic [IDX_W-1:0]     pickIdx,
  output logic                 anyReq
);

  // One extra bit holds ptr+k before the wrap; ptr+k never reaches 2*NUM_PORTS.
  localparam logic [IDX_W:0] NP = (IDX_W+1)'(NUM_PORTS);

  logic [IDX_W:0]   sum;
  logic [IDX_W-1:0] cIdx;
  logic             found;

  always_comb begin
    pickOh  = '0;
    pickIdx = '0;
    found   = 1'b0;
    sum     = '0;
    cIdx    = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      sum = {1'b0, ptr} + (IDX_W+1)'(k);
      if (sum >= NP) begin
        sum = sum - NP;
      end
      cIdx = sum[IDX_W-1:0];
      if (!found && req[cIdx]) begin
        found        = 1'b1;
        pickOh[cIdx] = 1'b1;
        pickIdx      = cIdx;
      end
    end
  end

  assign anyReq = |req;

endmodule

// File: rtl/aurora_tx_arbiter.sv
// Packet-level round-robin arbiter in front of the Aurora axiTxT* port.
// Optional per-port packet counters: define AURORA_TX_ARB_STATS_EN.
module aurora_tx_arbiter
  import auroraTxArbPkg::*;
#(
  parameter int NUM_PORTS     = 4,
  parameter int COUNTER_WIDTH = 16
) (
  input  logic                          auUserClk,
  input  logic                          auUserReset,
  input  logic [BEAT_W*NUM_PORTS-1:0]   sAxiTdata,
  input  logic [NUM_PORTS-1:0]          sAxiTlast,
  input  logic [NUM_PORTS-1:0]          sAxiTvalid,
  output logic [NUM_PORTS-1:0]          sAxiTready,
  output logic [BEAT_W-1:0]             mAxiTdata,
  output logic                          mAxiTlast,
  output logic                          mAxiTvalid,
  input  logic                          mAxiTready,
  output logic [NUM_PORTS-1:0]          grant,
  output logic                          busy,
  input  logic [$clog2(NUM_PORTS)-1:0]  statSel,
  output logic [COUNTER_WIDTH-1:0]      statCount
);

  localparam int IDX_W = $clog2(NUM_PORTS);

  arbState_t            state, stateNxt;
  logic [NUM_PORTS-1:0] grantReg, grantNxt, pickOh;
  logic [IDX_W-1:0]     grantIdx, idxNxt, rrPtr, ptrNxt, pickIdx;
  logic                 anyReq;
  logic                 pktDone;

  rrPicker #(
    .NUM_PORTS (NUM_PORTS),
    .IDX_W     (IDX_W)
  ) uPicker (
    .req     (sAxiTvalid),
    .ptr     (rrPtr),
    .pickOh  (pickOh),
    .pickIdx (pickIdx),
    .anyReq  (anyReq)
  );

  always_ff @(posedge auUserClk or posedge auUserReset) begin
    if (auUserReset) begin
      state    <= ARB_IDLE;
      grantReg <= '0;
      grantIdx <= '0;
      rrPtr    <= '0;
    end else begin
      state    <= stateNxt;
      grantReg <= grantNxt;
      grantIdx <= idxNxt;
      rrPtr    <= ptrNxt;
    end
  end

  always_comb begin
    stateNxt   = state;
    grantNxt   = grantReg;
    idxNxt     = grantIdx;
    ptrNxt     = rrPtr;
    mAxiTdata  = '0;
    mAxiTlast  = 1'b0;
    mAxiTvalid = 1'b0;
    sAxiTready = '0;
    pktDone    = 1'b0;
    case (state)
      ARB_IDLE: begin
        if (anyReq) begin
          stateNxt = ARB_PASS;
          grantNxt = pickOh;
          idxNxt   = pickIdx;
        end
      end
      ARB_PASS: begin
        // Zero-latency pass-through selected by the registered one-hot grant.
        for (int p = 0; p < NUM_PORTS; p++) begin
          if (grantReg[p]) begin
            mAxiTdata = sAxiTdata[p*BEAT_W +: BEAT_W];
          end
        end
        mAxiTlast  = |(grantReg & sAxiTlast);
        mAxiTvalid = |(grantReg & sAxiTvalid);
        sAxiTready = grantReg & {NUM_PORTS{mAxiTready}};
        if (mAxiTvalid && mAxiTready && mAxiTlast) begin
          pktDone  = 1'b1;
          stateNxt = ARB_IDLE;
          grantNxt = '0;
          ptrNxt   = (grantIdx == IDX_W'(NUM_PORTS-1)) ? '0 : grantIdx + 1'b1;
        end
      end
      default: begin
        stateNxt = ARB_IDLE;
        grantNxt = '0;
      end
    endcase
  end

  assign grant = grantReg;
  assign busy  = (state == ARB_PASS);

`ifdef AURORA_TX_ARB_STATS_EN
  logic [COUNTER_WIDTH-1:0] pktCnt [NUM_PORTS];
  logic [COUNTER_WIDTH-1:0] statReg;

  always_ff @(posedge auUserClk or posedge auUserReset) begin
    if (auUserReset) begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        pktCnt[p] <= '0;
      end
      statReg <= '0;
    end else begin
      if (pktDone) begin
        pktCnt[grantIdx] <= pktCnt[grantIdx] + 1'b1;
      end
      if (int'(statSel) < NUM_PORTS) begin
        statReg <= pktCnt[statSel];
      end else begin
        statReg <= '0;
      end
    end
  end

  assign statCount = statReg;
`else
  logic unusedStats;
  assign unusedStats = ^{statSel, pktDone};
  assign statCount   = '0;
`endif

endmodule

// File: tb/tb_aurora_tx_arbiter.sv
// Scoreboard bench for aurora_tx_arbiter: per-port source queues feed the DUT,
// expected beats are queued in predicted arbitration order and popped on each link beat.
module tb_aurora_tx_arbiter;
  localparam int NP = 4;

  typedef struct packed {
    logic [1:0]  port;
    logic        last;
    logic [31:0] data;
  } beat_t;

  logic              auUserClk = 1'b0;
  logic              auUserReset = 1'b1;
  logic [32*NP-1:0]  sAxiTdata = '0;
  logic [NP-1:0]     sAxiTlast = '0;
  logic [NP-1:0]     sAxiTvalid = '0;
  logic [NP-1:0]     sAxiTready;
  logic [31:0]       mAxiTdata;
  logic              mAxiTlast;
  logic              mAxiTvalid;
  logic              mAxiTready = 1'b1;
  logic [NP-1:0]     grant;
  logic              busy;
  logic [1:0]        statSel = '0;
  logic [15:0]       statCount;

  beat_t       expQ[$];
  logic [32:0] srcQ[NP][$];
  int          beatCyc[$];
  int          cyc = 0;
  logic [NP-1:0] acc = '0;
  logic [NP-1:0] hold = '0;
  bit          readyMode = 1'b0;
  int          statSelV = 0;
  int          total = 0;
  int          bad = 0;

  aurora_tx_arbiter #(.NUM_PORTS(NP), .COUNTER_WIDTH(16)) dut (
    .auUserClk   (auUserClk),
    .auUserReset (auUserReset),
    .sAxiTdata   (sAxiTdata),
    .sAxiTlast   (sAxiTlast),
    .sAxiTvalid  (sAxiTvalid),
    .sAxiTready  (sAxiTready),
    .mAxiTdata   (mAxiTdata),
    .mAxiTlast   (mAxiTlast),
    .mAxiTvalid  (mAxiTvalid),
    .mAxiTready  (mAxiTready),
    .grant       (grant),
    .busy        (busy),
    .statSel     (statSel),
    .statCount   (statCount)
  );

  always #5 auUserClk = ~auUserClk;
  always @(posedge auUserClk) cyc++;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Input driver: one step after each rising edge, retire accepted beats and present the next.
  always @(posedge auUserClk) begin
    logic [32:0] hd;
    #1;
    if (!auUserReset) begin
      for (int p = 0; p < NP; p++) begin
        if (acc[p] && srcQ[p].size() > 0) void'(srcQ[p].pop_front());
      end
    end
    for (int p = 0; p < NP; p++) begin
      if (srcQ[p].size() > 0 && !hold[p]) begin
        hd = srcQ[p][0];
        sAxiTvalid[p] = 1'b1;
        sAxiTlast[p]  = hd[32];
        sAxiTdata[p*32 +: 32] = hd[31:0];
      end else begin
        sAxiTvalid[p] = 1'b0;
        sAxiTlast[p]  = 1'b0;
        sAxiTdata[p*32 +: 32] = '0;
      end
    end
    mAxiTready = readyMode ? ~mAxiTready : 1'b1;
    statSel = 2'(statSelV);
  end

  // Monitor: mid-cycle sampling of handshakes and link beats.
  always @(negedge auUserClk) begin
    beat_t e;
    if (auUserReset) begin
      acc = '0;
    end else begin
      acc = sAxiTvalid & sAxiTready;
      checkVal("readyOnlyGranted", 32'(sAxiTready & ~grant), 32'd0);
      if (mAxiTvalid && mAxiTready) begin
        beatCyc.push_back(cyc);
        if (expQ.size() == 0) begin
          checkVal("unexpectedBeat", mAxiTdata, 32'hDEAD_BEEF);
        end else begin
          e = expQ.pop_front();
          checkVal("beatData", mAxiTdata, e.data);
          checkVal("beatLast", 32'(mAxiTlast), 32'(e.last));
          checkVal("beatGrant", 32'(grant), 32'(1) << e.port);
        end
      end
    end
  end

  task automatic tick();
    @(negedge auUserClk);
    #1;
  endtask

  task automatic srcPkt(input int port, input int n, input logic [31:0] base);
    for (int i = 0; i < n; i++) srcQ[port].push_back({(i == n-1), base + 32'(i)});
  endtask

  task automatic expPkt(input int port, input int n, input logic [31:0] base);
    beat_t b;
    for (int i = 0; i < n; i++) begin
      b.port = 2'(port);
      b.last = (i == n-1);
      b.data = base + 32'(i);
      expQ.push_back(b);
    end
  endtask

  task automatic flushAll();
    expQ.delete();
    beatCyc.delete();
    for (int p = 0; p < NP; p++) srcQ[p].delete();
    hold = '0;
    readyMode = 1'b0;
  endtask

  task automatic doReset();
    auUserReset = 1'b1;
    flushAll();
    tick();
    tick();
    auUserReset = 1'b0;
    tick();
  endtask

  task automatic waitDrain(input string tag, input int budget);
    for (int i = 0; i < budget && expQ.size() > 0; i++) tick();
    checkVal(tag, 32'(expQ.size()), 32'd0);
  endtask

  task automatic waitBeats(input string tag, input int n, input int budget);
    for (int i = 0; i < budget && beatCyc.size() < n; i++) tick();
    checkVal(tag, 32'(beatCyc.size() >= n), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    doReset();
    checkVal("rstGrant", 32'(grant), 32'd0);
    checkVal("rstBusy", 32'(busy), 32'd0);
    checkVal("rstValid", 32'(mAxiTvalid), 32'd0);
    checkVal("rstReady", 32'(sAxiTready), 32'd0);
    checkVal("rstStat", 32'(statCount), 32'd0);

    // 1: port 2 alone, 3 beats, arbitration bubble then contiguous beats
    srcPkt(2, 3, 32'hA0);
    expPkt(2, 3, 32'hA0);
    tick();
    checkVal("t1IdleGrant", 32'(grant), 32'd0);
    checkVal("t1IdleValid", 32'(mAxiTvalid), 32'd0);
    checkVal("t1IdleData", mAxiTdata, 32'd0);
    checkVal("t1IdleBusy", 32'(busy), 32'd0);
    tick();
    checkVal("t1Grant", 32'(grant), 32'b0100);
    checkVal("t1Busy", 32'(busy), 32'd1);
    checkVal("t1Beat0", mAxiTdata, 32'hA0);
    tick();
    checkVal("t1Beat1", mAxiTdata, 32'hA1);
    checkVal("t1Valid1", 32'(mAxiTvalid), 32'd1);
    tick();
    checkVal("t1Beat2", mAxiTdata, 32'hA2);
    checkVal("t1Last2", 32'(mAxiTlast), 32'd1);
    tick();
    checkVal("t1GrantDone", 32'(grant), 32'd0);
    checkVal("t1BusyDone", 32'(busy), 32'd0);
    waitDrain("t1Drain", 5);

    // 2: all ports, 2-beat packets, order 0,1,2,3,0 with one bubble each
    doReset();
    for (int p = 0; p < NP; p++) srcPkt(p, 2, 32'h100 * (p + 1));
    srcPkt(0, 2, 32'h500);
    for (int p = 0; p < NP; p++) expPkt(p, 2, 32'h100 * (p + 1));
    expPkt(0, 2, 32'h500);
    waitDrain("t2Drain", 60);
    checkVal("t2BeatCount", 32'(beatCyc.size()), 32'd10);
    if (beatCyc.size() == 10) checkVal("t2Span", 32'(beatCyc[9] - beatCyc[0]), 32'd13);

    // 3: port 1 granted, ready toggling, port 0 waiting
    doReset();
    readyMode = 1'b1;
    srcPkt(1, 4, 32'hB0);
    expPkt(1, 4, 32'hB0);
    for (int i = 0; i < 10 && grant != 4'b0010; i++) tick();
    checkVal("t3Grant", 32'(grant), 32'b0010);
    srcPkt(0, 2, 32'hC0);
    expPkt(0, 2, 32'hC0);
    for (int i = 0; i < 40 && grant == 4'b0010; i++) begin
      checkVal("t3P0NotReady", 32'(sAxiTready[0]), 32'd0);
      tick();
    end
    waitDrain("t3Drain", 40);
    readyMode = 1'b0;

    // 4: port 3 drops valid mid-packet for 5 cycles while port 0 requests
    doReset();
    srcPkt(3, 4, 32'hD0);
    expPkt(3, 4, 32'hD0);
    waitBeats("t4FirstBeat", 1, 10);
    hold[3] = 1'b1;
    srcPkt(0, 2, 32'hE0);
    expPkt(0, 2, 32'hE0);
    for (int i = 0; i < 5; i++) begin
      tick();
      checkVal("t4GapValid", 32'(mAxiTvalid), 32'd0);
      checkVal("t4GapGrant", 32'(grant), 32'b1000);
    end
    hold[3] = 1'b0;
    waitDrain("t4Drain", 30);

    // 5: reset on beat 2 of a 4-beat packet
    doReset();
    srcPkt(1, 4, 32'hF0);
    expPkt(1, 4, 32'hF0);
    waitBeats("t5FirstBeat", 1, 10);
    tick();
    auUserReset = 1'b1;
    #1;
    checkVal("t5Grant", 32'(grant), 32'd0);
    checkVal("t5Busy", 32'(busy), 32'd0);
    checkVal("t5Valid", 32'(mAxiTvalid), 32'd0);
    checkVal("t5Data", mAxiTdata, 32'd0);
    checkVal("t5Ready", 32'(sAxiTready), 32'd0);
    checkVal("t5Stat", 32'(statCount), 32'd0);
    flushAll();
    tick();
    tick();
    auUserReset = 1'b0;
    tick();
    srcPkt(3, 1, 32'h33);
    srcPkt(0, 1, 32'h11);
    expPkt(0, 1, 32'h11);
    expPkt(3, 1, 32'h33);
    waitDrain("t5Drain", 20);

    // 6: single-beat packets and the per-port counters
    doReset();
    srcPkt(1, 1, 32'h61);
    srcPkt(1, 1, 32'h62);
    srcPkt(1, 1, 32'h63);
    srcPkt(2, 1, 32'h71);
    expPkt(1, 1, 32'h61);
    expPkt(2, 1, 32'h71);
    expPkt(1, 1, 32'h62);
    expPkt(1, 1, 32'h63);
    waitDrain("t6Drain", 30);
    checkVal("t6BeatCount", 32'(beatCyc.size()), 32'd4);
    if (beatCyc.size() == 4) checkVal("t6Span", 32'(beatCyc[3] - beatCyc[0]), 32'd6);
    statSelV = 1;
    tick(); tick(); tick();
`ifdef AURORA_TX_ARB_STATS_EN
    checkVal("t6Stat1", 32'(statCount), 32'd3);
`else
    checkVal("t6Stat1", 32'(statCount), 32'd0);
`endif
    statSelV = 2;
    tick(); tick(); tick();
`ifdef AURORA_TX_ARB_STATS_EN
    checkVal("t6Stat2", 32'(statCount), 32'd1);
`else
    checkVal("t6Stat2", 32'(statCount), 32'd0);
`endif
    statSelV = 3;
    tick(); tick(); tick();
    checkVal("t6Stat3", 32'(statCount), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
